// File: rtl/ras_ckpt_stack.sv
// Return-address stack: speculative copy + committed checkpoint, one-cycle flush restore, 1-cycle update latency, no backpressure.
// Optional recursion-counter compression of repeated pushes when RAS_RECUR_CNT_EN is defined.

module ras_ckpt_stack_nxt #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3,
    parameter int CNT_OW = 4
`ifdef RAS_RECUR_CNT_EN
    ,
    parameter int CNT_W  = 2
`endif
) (
    input  logic                           push_i,
    input  logic                           pop_i,
    input  logic [ADDR_W-1:0]              addr_i,
    input  logic [DEPTH-1:0][ADDR_W-1:0]   ent_i,
    input  logic [PTR_W-1:0]               top_i,
    input  logic [CNT_OW-1:0]              cnt_i,
    output logic [DEPTH-1:0][ADDR_W-1:0]   ent_o,
    output logic [PTR_W-1:0]               top_o,
    output logic [CNT_OW-1:0]              cnt_o
`ifdef RAS_RECUR_CNT_EN
    ,
    input  logic [DEPTH-1:0][CNT_W-1:0]    ctr_i,
    output logic [DEPTH-1:0][CNT_W-1:0]    ctr_o
`endif
);

    logic [PTR_W-1:0] top_inc;
    logic [PTR_W-1:0] top_dec;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign top_inc = top_i + 1'b1;
    assign top_dec = top_i - 1'b1;
    assign empty   = (cnt_i == '0);
    assign full    = (cnt_i == CNT_OW'(DEPTH));

    always_comb begin
        ent_o   = ent_i;
        top_o   = top_i;
        cnt_o   = cnt_i;
`ifdef RAS_RECUR_CNT_EN
        ctr_o   = ctr_i;
`endif
        do_push = 1'b0;
        do_pop  = 1'b0;

        // Push+pop replaces the top in place; on an empty stack it degrades to a plain push.
        if (push_i && pop_i && !empty) begin
            ent_o[top_i] = addr_i;
`ifdef RAS_RECUR_CNT_EN
            ctr_o[top_i] = '0;
`endif
        end else if (push_i) begin
`ifdef RAS_RECUR_CNT_EN
            if (!empty && (ent_i[top_i] == addr_i) && (ctr_i[top_i] != '1)) begin
                ctr_o[top_i] = ctr_i[top_i] + 1'b1;
            end else begin
                do_push = 1'b1;
            end
`else
            do_push = 1'b1;
`endif
        end else if (pop_i && !empty) begin
`ifdef RAS_RECUR_CNT_EN
            if (ctr_i[top_i] != '0) begin
                ctr_o[top_i] = ctr_i[top_i] - 1'b1;
            end else begin
                do_pop = 1'b1;
            end
`else
            do_pop = 1'b1;
`endif
        end

        // When full the pointer wraps onto the oldest entry and overwrites it.
        if (do_push) begin
            top_o          = top_inc;
            ent_o[top_inc] = addr_i;
`ifdef RAS_RECUR_CNT_EN
            ctr_o[top_inc] = '0;
`endif
            if (!full) begin
                cnt_o = cnt_i + 1'b1;
            end
        end

        if (do_pop) begin
            top_o = top_dec;
            cnt_o = cnt_i - 1'b1;
        end
    end

endmodule

module ras_ckpt_stack #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 8,
    parameter int LINK_OFFSET = 8
`ifdef RAS_RECUR_CNT_EN
    ,
    parameter int CNT_W       = 2
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         spec_push_i,
    input  logic                         spec_pop_i,
    input  logic [ADDR_W-1:0]            spec_push_addr_i,
    output logic [ADDR_W-1:0]            spec_top_o,
    output logic                         spec_valid_o,
    output logic [$clog2(DEPTH+1)-1:0]   spec_count_o,
    input  logic                         cmt_link_i,
    input  logic                         cmt_ret_i,
    input  logic [ADDR_W-1:0]            cmt_pc_i
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_OW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][ADDR_W-1:0] spec_ent_q, spec_ent_d;
    logic [PTR_W-1:0]             spec_top_q, spec_top_d;
    logic [CNT_OW-1:0]            spec_cnt_q, spec_cnt_d;
    logic [DEPTH-1:0][ADDR_W-1:0] cmt_ent_q, cmt_ent_d;
    logic [PTR_W-1:0]             cmt_top_q, cmt_top_d;
    logic [CNT_OW-1:0]            cmt_cnt_q, cmt_cnt_d;
    logic [ADDR_W-1:0]            cmt_addr;
`ifdef RAS_RECUR_CNT_EN
    logic [DEPTH-1:0][CNT_W-1:0]  spec_ctr_q, spec_ctr_d;
    logic [DEPTH-1:0][CNT_W-1:0]  cmt_ctr_q, cmt_ctr_d;
`endif

    assign cmt_addr = cmt_pc_i + ADDR_W'(LINK_OFFSET);

    ras_ckpt_stack_nxt #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W),
        .CNT_OW (CNT_OW)
`ifdef RAS_RECUR_CNT_EN
        ,
        .CNT_W  (CNT_W)
`endif
    ) u_spec_nxt (
        .push_i (spec_push_i),
        .pop_i  (spec_pop_i),
        .addr_i (spec_push_addr_i),
        .ent_i  (spec_ent_q),
        .top_i  (spec_top_q),
        .cnt_i  (spec_cnt_q),
        .ent_o  (spec_ent_d),
        .top_o  (spec_top_d),
        .cnt_o  (spec_cnt_d)
`ifdef RAS_RECUR_CNT_EN
        ,
        .ctr_i  (spec_ctr_q),
        .ctr_o  (spec_ctr_d)
`endif
    );

    ras_ckpt_stack_nxt #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W),
        .CNT_OW (CNT_OW)
`ifdef RAS_RECUR_CNT_EN
        ,
        .CNT_W  (CNT_W)
`endif
    ) u_cmt_nxt (
        .push_i (cmt_link_i),
        .pop_i  (cmt_ret_i),
        .addr_i (cmt_addr),
        .ent_i  (cmt_ent_q),
        .top_i  (cmt_top_q),
        .cnt_i  (cmt_cnt_q),
        .ent_o  (cmt_ent_d),
        .top_o  (cmt_top_d),
        .cnt_o  (cmt_cnt_d)
`ifdef RAS_RECUR_CNT_EN
        ,
        .ctr_i  (cmt_ctr_q),
        .ctr_o  (cmt_ctr_d)
`endif
    );

    // Flush takes the committed next state so a same-cycle link/return is already reflected.
    always_ff @(posedge clk) begin
        if (rst) begin
            spec_ent_q <= '0;
            spec_top_q <= PTR_W'(DEPTH - 1);
            spec_cnt_q <= '0;
            cmt_ent_q  <= '0;
            cmt_top_q  <= PTR_W'(DEPTH - 1);
            cmt_cnt_q  <= '0;
`ifdef RAS_RECUR_CNT_EN
            spec_ctr_q <= '0;
            cmt_ctr_q  <= '0;
`endif
        end else begin
            cmt_ent_q <= cmt_ent_d;
            cmt_top_q <= cmt_top_d;
            cmt_cnt_q <= cmt_cnt_d;
`ifdef RAS_RECUR_CNT_EN
            cmt_ctr_q <= cmt_ctr_d;
`endif
            if (flush_i) begin
                spec_ent_q <= cmt_ent_d;
                spec_top_q <= cmt_top_d;
                spec_cnt_q <= cmt_cnt_d;
`ifdef RAS_RECUR_CNT_EN
                spec_ctr_q <= cmt_ctr_d;
`endif
            end else begin
                spec_ent_q <= spec_ent_d;
                spec_top_q <= spec_top_d;
                spec_cnt_q <= spec_cnt_d;
`ifdef RAS_RECUR_CNT_EN
                spec_ctr_q <= spec_ctr_d;
`endif
            end
        end
    end

    assign spec_top_o   = spec_ent_q[spec_top_q];
    assign spec_valid_o = (spec_cnt_q != '0);
    assign spec_count_o = spec_cnt_q;

endmodule

// File: tb/tb_ras_ckpt_stack.sv
// Scoreboard bench for ras_ckpt_stack: queue-based stack model, directed scenarios then random traffic.
module tb_ras_ckpt_stack;

    localparam int AW = 32;
    localparam int D  = 4;
    localparam int LO = 8;
    localparam int CW = $clog2(D + 1);
    localparam int CTR_MAX = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush_i = 1'b0;
    logic          spec_push_i = 1'b0;
    logic          spec_pop_i = 1'b0;
    logic [AW-1:0] spec_push_addr_i = '0;
    logic [AW-1:0] spec_top_o;
    logic          spec_valid_o;
    logic [CW-1:0] spec_count_o;
    logic          cmt_link_i = 1'b0;
    logic          cmt_ret_i = 1'b0;
    logic [AW-1:0] cmt_pc_i = '0;

    ras_ckpt_stack #(.ADDR_W(AW), .DEPTH(D), .LINK_OFFSET(LO)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush_i          (flush_i),
        .spec_push_i      (spec_push_i),
        .spec_pop_i       (spec_pop_i),
        .spec_push_addr_i (spec_push_addr_i),
        .spec_top_o       (spec_top_o),
        .spec_valid_o     (spec_valid_o),
        .spec_count_o     (spec_count_o),
        .cmt_link_i       (cmt_link_i),
        .cmt_ret_i        (cmt_ret_i),
        .cmt_pc_i         (cmt_pc_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        int            ctr;
    } ent_t;
    typedef ent_t ent_q_t[$];

    typedef struct {
        int            tag;
        logic [AW-1:0] top;
        bit            chk_top;
        int            cnt;
    } exp_t;

    exp_t   exp_q[$];
    ent_q_t spec_m;
    ent_q_t cmt_m;
    int     n_chk = 0;
    int     n_fail = 0;

    // Live contents only, oldest at the front; overflow discards the front.
    function automatic ent_q_t apply(input ent_q_t s, input bit push, input bit pop, input logic [AW-1:0] a);
        ent_q_t r;
        ent_t   e;
        r = s;
        if (push && pop && r.size() > 0) begin
            e.addr = a;
            e.ctr  = 0;
            r[r.size()-1] = e;
        end else if (push) begin
`ifdef RAS_RECUR_CNT_EN
            if (r.size() > 0 && r[r.size()-1].addr == a && r[r.size()-1].ctr < CTR_MAX) begin
                e = r[r.size()-1];
                e.ctr = e.ctr + 1;
                r[r.size()-1] = e;
                return r;
            end
`endif
            if (r.size() == D) void'(r.pop_front());
            e.addr = a;
            e.ctr  = 0;
            r.push_back(e);
        end else if (pop && r.size() > 0) begin
`ifdef RAS_RECUR_CNT_EN
            if (r[r.size()-1].ctr > 0) begin
                e = r[r.size()-1];
                e.ctr = e.ctr - 1;
                r[r.size()-1] = e;
                return r;
            end
`endif
            void'(r.pop_back());
        end
        return r;
    endfunction

    task automatic step(input bit r, input bit f, input bit sp, input bit spp, input logic [AW-1:0] sa,
                        input bit cl, input bit cr, input logic [AW-1:0] pc);
        ent_q_t cn;
        exp_t   e;
        logic [AW-1:0] link_addr;
        @(posedge clk);
        #1;
        rst = r;
        flush_i = f;
        spec_push_i = sp;
        spec_pop_i = spp;
        spec_push_addr_i = sa;
        cmt_link_i = cl;
        cmt_ret_i = cr;
        cmt_pc_i = pc;
        link_addr = pc + AW'(LO);
        cn = apply(cmt_m, cl, cr, link_addr);
        if (r) begin
            cmt_m = {};
            spec_m = {};
        end else begin
            spec_m = f ? cn : apply(spec_m, sp, spp, sa);
            cmt_m = cn;
        end
        e.tag = cyc + 1;
        e.cnt = spec_m.size();
        e.chk_top = (e.cnt != 0);
        e.top = e.chk_top ? spec_m[e.cnt-1].addr : '0;
        exp_q.push_back(e);
    endtask

    task automatic sp(input bit push, input bit pop, input logic [AW-1:0] a);
        step(0, 0, push, pop, a, 0, 0, '0);
    endtask

    initial begin : monitor
        exp_t e;
        logic [CW-1:0] ecnt;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].tag <= cyc) begin
                e = exp_q.pop_front();
                ecnt = CW'(e.cnt);
                n_chk++;
                if (spec_count_o !== ecnt) begin
                    n_fail++;
                    $display("FAIL count cyc=%0d got=%0d exp=%0d", cyc, spec_count_o, ecnt);
                end
                n_chk++;
                if (spec_valid_o !== (e.cnt != 0)) begin
                    n_fail++;
                    $display("FAIL valid cyc=%0d got=%0b exp=%0b", cyc, spec_valid_o, e.cnt != 0);
                end
                if (e.chk_top) begin
                    n_chk++;
                    if (spec_top_o !== e.top) begin
                        n_fail++;
                        $display("FAIL top cyc=%0d got=%h exp=%h", cyc, spec_top_o, e.top);
                    end
                end
            end
        end
    end

    initial begin : stim
        step(1, 0, 0, 0, '0, 0, 0, '0);
        step(1, 0, 0, 0, '0, 0, 0, '0);
        sp(0, 0, '0);
        // Basic push / pop
        sp(1, 0, 32'h100);
        sp(1, 0, 32'h200);
        sp(0, 1, '0);
        sp(0, 1, '0);
        // Overflow then drain past empty
        sp(1, 0, 32'h10);
        sp(1, 0, 32'h20);
        sp(1, 0, 32'h30);
        sp(1, 0, 32'h40);
        sp(1, 0, 32'h50);
        for (int i = 0; i < 5; i++) sp(0, 1, '0);
        // Replace top with simultaneous push+pop, and on empty
        sp(1, 0, 32'h100);
        sp(1, 1, 32'h300);
        sp(0, 1, '0);
        sp(1, 1, 32'h777);
        // Flush restores committed state; spec push in flush cycle ignored
        step(1, 0, 0, 0, '0, 0, 0, '0);
        step(0, 0, 0, 0, '0, 1, 0, 32'h1000);
        sp(1, 0, 32'hAAA);
        sp(1, 0, 32'hBBB);
        step(0, 1, 1, 0, 32'hCCC, 0, 0, '0);
        // Flush together with a committed return
        step(0, 0, 0, 0, '0, 1, 0, 32'h2000);
        sp(1, 0, 32'hDDD);
        step(0, 1, 0, 0, '0, 0, 1, '0);
        // Reset asserted alongside flush
        step(1, 1, 1, 0, 32'h123, 1, 0, 32'h40);
        // Repeated address (compressed under recursion counting)
        for (int i = 0; i < 5; i++) sp(1, 0, 32'h500);
        for (int i = 0; i < 6; i++) sp(0, 1, '0);
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 149) == 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                 AW'($urandom_range(1, 4) * 16),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                 AW'($urandom_range(1, 3) * 256));
        end
        step(0, 0, 0, 0, '0, 0, 0, '0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ras_ckpt_stack.md
Name: ras_ckpt_stack

Overview:
- Parametrised return-address stack for the IF branch predictor.
- Holds a speculative stack, updated by fetch-side push/pop predictions, and a committed stack, updated by decoder-resolved link/return events.
- Flush restores the speculative stack from the committed stack in one cycle.
- Adds circular overwrite on overflow, empty protection, occupancy reporting and optional recursion-counter compression.

Parameters:
- ADDR_W, 32, address width.
- DEPTH, 8, entries per stack; power of two, >= 2.
- CNT_W, 2, width of the per-entry recursion counter; used only with RAS_RECUR_CNT_EN.
- LINK_OFFSET, 8, added to cmt_pc_i to form the committed return address.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- flush_i  in  1  restore speculative state from committed state.
- spec_push_i  in  1  fetch predicts a call.
- spec_pop_i  in  1  fetch predicts a return.
- spec_push_addr_i  in  ADDR_W  return address to push.
- spec_top_o  out  ADDR_W  predicted return address (top of speculative stack).
- spec_valid_o  out  1  speculative stack non-empty.
- spec_count_o  out  $clog2(DEPTH+1)  speculative occupancy.
- cmt_link_i  in  1  decoder-resolved call.
- cmt_ret_i  in  1  decoder-resolved return.
- cmt_pc_i  in  ADDR_W  PC of the resolved call.

Behaviour:
- One clock (clk). Reset is synchronous and active-high on rst.
- Both stacks use identical update logic: entry array, top pointer (log2 DEPTH bits, wraps modulo DEPTH), occupancy count (0..DEPTH), per-entry counter.
- Reset: all entries 0, top = DEPTH-1, count = 0, counters = 0.
  - Outputs after reset: spec_top_o = 0, spec_valid_o = 0, spec_count_o = 0.
  - rst has priority over all other inputs, including mid-flush.
- Push only:
  - top <= top+1 (wrap), entry[top+1] <= addr, counter <= 0.
  - count <= min(count+1, DEPTH).
  - When full, the oldest entry is silently overwritten.
- Pop only:
  - If count == 0: no state change (underflow ignored).
  - Else: top <= top-1 (wrap), count <= count-1.
- Push and pop in the same cycle:
  - entry[top] <= addr, counter[top] <= 0; top and count unchanged.
  - If count == 0, treated as push only.
- Committed stack uses cmt_link_i as push, cmt_ret_i as pop, addr = cmt_pc_i + LINK_OFFSET truncated to ADDR_W.
- Flush:
  - Speculative entries, top, count and counters <= the committed stack's next-state values, including any commit event in the same cycle.
  - spec_push_i / spec_pop_i in the flush cycle are ignored.
  - The committed stack updates normally during flush.
- Latency: all updates take effect at the clock edge.
  - spec_top_o = entry[top] of the speculative stack, combinational from registered state; reads 0 only in the sense of holding stale contents when empty.
  - A push at edge N is visible on spec_top_o after edge N; no same-cycle bypass.
- spec_valid_o = (count != 0); spec_count_o = count.
- Stale entries below the top are never cleared on pop.

Optional Feature:
- Macro: RAS_RECUR_CNT_EN.
- Defined:
  - A push whose addr equals entry[top], with count != 0 and counter[top] < 2^CNT_W-1, only increments counter[top]; top and count are unchanged.
  - A pop with counter[top] > 0 only decrements counter[top].
  - A push+pop in the same cycle still overwrites the top entry and clears its counter.
  - Applies identically to the committed stack, and counters are copied on flush.
- Undefined: no counter storage; every push allocates an entry per the base rules.

Test Plan (DEPTH=4, LINK_OFFSET=8):
- Reset, then push 0x100, 0x200 on consecutive cycles -> after 2nd edge spec_top_o=0x200, spec_count_o=2; one pop -> spec_top_o=0x100, count=1.
- Push 0x10, 0x20, 0x30, 0x40, 0x50 -> count saturates at 4; spec_top_o=0x50; four pops -> 0x40, 0x30, 0x20, then count=0, spec_valid_o=0; extra pop leaves count=0.
- Push 0x100, then a same-cycle push 0x300 + pop -> spec_top_o=0x300, count=1.
- cmt_link_i with cmt_pc_i=0x1000; speculative pushes 0xAAA, 0xBBB; flush_i -> next cycle spec_top_o=0x1008, count=1; spec_push_i asserted in the flush cycle is ignored.
- flush_i in the same cycle as cmt_ret_i with committed count=2 (0x1008 under 0x2008) -> spec_top_o=0x1008, count=1.
- With RAS_RECUR_CNT_EN, CNT_W=2: push 0x500 four times -> count=1, counter=3; 5th push -> count=2; pops return 0x500 five times before empty.
